load_store_unit: RTL and testbench

//  Memory-stage load/store engine of the RV32I pipeline; single Wishbone (pipelined) master in front of the data memory.

---
 rtl/load_store_unit_pkg.sv | 57 +++++
 rtl/load_store_unit_load_align.sv | 28 ++
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I memory-stage load/store unit:
// funct3 codes, result codes, FSM state encodings and lane helpers.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_FUNCT3   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } lsu_err_e;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // Unsigned variants only exist for loads; stores accept B/H/W alone.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: f3_illegal = 1'b0;
      F3_BU, F3_HU:     f3_illegal = is_store;
      default:          f3_illegal = 1'b1;
    endcase
  endfunction

  // size: funct3[1:0] (00 byte, 01 half, 10 word)
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_sel = 4'b0001 << off;
      2'b01:   lane_sel = off[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   store_replicate = {4{data[7:0]}};
      2'b01:   store_replicate = {2{data[15:0]}};
      default: store_replicate = data;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data formatter: picks the addressed byte/half out of the bus word
// and sign- or zero-extends it according to funct3.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [15:0] shifted;

  assign shifted = 16'(raw_i >> {off_i, 3'b000});

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      F3_W:    data_o = raw_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: one pipelined Wishbone transaction per
// MEM-stage request, with fault checks, lane steering and ack timeout.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int AW      = 13,
  parameter int TIMEOUT = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic          i_is_store,
  input  logic [2:0]    i_funct3,
  input  logic [31:0]   i_addr,
  input  logic [31:0]   i_store_data,
  output logic          o_stall,
  output logic          o_done,
  output logic [31:0]   o_load_data,
  output logic [1:0]    o_err_code,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic [31:0]   i_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    sel_q, sel_d;
  logic [2:0]    f3_q, f3_d;
  logic          done_q, done_d;
  logic [31:0]   ldata_q, ldata_d;
  logic [1:0]    err_q, err_d;

  logic [31:0]   aligned;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;
  logic          bus_accepted;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^i_addr[31:AW];

  lsu_load_align u_load_align (
    .raw_i    (i_wb_data),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (aligned)
  );

  assign cnt_inc      = cnt_q + CW'(1);
  assign timeout_hit  = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));
  // An ack only counts once the strobe has been taken (stall low in REQ).
  assign bus_accepted = (state_q == ST_WAIT) || !i_wb_stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    f3_d    = f3_q;
    done_d  = 1'b0;
    ldata_d = ldata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_req) begin
          if (f3_illegal(i_funct3, i_is_store)) begin
            err_d   = ERR_FUNCT3;
            ldata_d = '0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (misaligned(i_funct3[1:0], i_addr[1:0])) begin
            err_d   = ERR_MISALIGN;
            ldata_d = '0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = i_is_store;
            addr_d  = i_addr[AW-1:0];
            wdata_d = store_replicate(i_funct3[1:0], i_store_data);
            sel_d   = lane_sel(i_funct3[1:0], i_addr[1:0]);
            f3_d    = i_funct3;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ, ST_WAIT: begin
        if (bus_accepted && i_wb_ack) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          ldata_d = we_q ? 32'h0 : aligned;
          err_d   = ERR_OK;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          ldata_d = '0;
          err_d   = ERR_TIMEOUT;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (state_q == ST_REQ && !i_wb_stall) begin
            stb_d   = 1'b0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      f3_q    <= '0;
      done_q  <= 1'b0;
      ldata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      f3_q    <= f3_d;
      done_q  <= done_d;
      ldata_q <= ldata_d;
      err_q   <= err_d;
    end
  end

  assign o_stall     = i_req && (state_q != ST_DONE);
  assign o_done      = done_q;
  assign o_load_data = ldata_q;
  assign o_err_code  = err_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = wdata_q;
  assign o_wb_sel    = sel_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, hand-written
// stall/timeout/reset sequences, and random ops against a byte-level model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, sdata;
  logic        stall, done;
  logic [31:0] ld;
  logic [1:0]  err;
  logic        cyc, stb, we;
  logic [12:0] wbaddr;
  logic [31:0] wbdata, wb_rdata;
  logic [3:0]  sel;
  logic        ack, wb_stall;

  int errors = 0;
  int checks = 0;

  logic [31:0] slv_mem [0:63];
  logic [7:0]  ref_mem [0:255];

  always #5 clk = ~clk;

  load_store_unit #(.AW(13), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_is_store(is_store),
    .i_funct3(funct3), .i_addr(addr), .i_store_data(sdata),
    .o_stall(stall), .o_done(done), .o_load_data(ld), .o_err_code(err),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_addr(wbaddr),
    .o_wb_data(wbdata), .o_wb_sel(sel), .i_wb_data(wb_rdata),
    .i_wb_ack(ack), .i_wb_stall(wb_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        got_done;
    int          latency;
    logic [31:0] ld;
    logic [1:0]  err;
    logic        cyc_seen;
    int          stb_cycles;
    int          cyc_cycles;
    logic [3:0]  sel;
    logic [31:0] wbdata;
    logic        we;
    logic        stall_ok;
  } res_t;

  // Drives one request and plays the Wishbone slave cycle by cycle on the falling edge.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int stall_n, input int ack_delay,
                        input logic noack, output res_t r);
    int stall_left;
    int cd;
    r = '{1'b0, 0, 32'h0, 2'b00, 1'b0, 0, 0, 4'h0, 32'h0, 1'b0, 1'b1};
    stall_left = stall_n;
    cd = 0;
    @(negedge clk);
    req = 1'b1; is_store = st; funct3 = f3; addr = a; sdata = d;
    ack = 1'b0; wb_stall = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      ack = 1'b0; wb_stall = 1'b0;
      if (done) begin
        r.got_done = 1'b1; r.latency = n; r.ld = ld; r.err = err;
        if (stall !== 1'b0) r.stall_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1) r.stall_ok = 1'b0;
      if (cyc) begin r.cyc_seen = 1'b1; r.cyc_cycles++; end
      if (cyc && stb) begin
        r.stb_cycles++; r.sel = sel; r.wbdata = wbdata; r.we = we;
        if (stall_left > 0) begin
          wb_stall = 1'b1; stall_left--;
        end else begin
          if (we)
            for (int b = 0; b < 4; b++)
              if (sel[b]) slv_mem[wbaddr[7:2]][8*b +: 8] = wbdata[8*b +: 8];
          if (!noack) begin
            if (ack_delay == 0) begin ack = 1'b1; wb_rdata = slv_mem[wbaddr[7:2]]; end
            else cd = ack_delay;
          end
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin ack = 1'b1; wb_rdata = slv_mem[wbaddr[7:2]]; end
      end
    end
    req = 1'b0; ack = 1'b0; wb_stall = 1'b0;
    chk("op_done_seen", {31'h0, r.got_done}, 32'h1);
    chk("stall_shape", {31'h0, r.stall_ok}, 32'h1);
  endtask

  // Reference model: byte-addressed memory and RV32I rules expressed arithmetically.
  function automatic logic [1:0] model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int nb;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (st && f3 >= 3'd4)) return 2'b10;
    nb = 1 << f3[1:0];
    if ((a % nb) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int nb;
    logic [31:0] v;
    nb = 1 << f3[1:0];
    v = 0;
    for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[(a + i) % 256]) << (8 * i));
    if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 1);
    return v;
  endfunction

  function automatic logic [3:0] model_sel(input logic [2:0] f3, input logic [31:0] a);
    int nb;
    nb = 1 << f3[1:0];
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wbdata(input logic [2:0] f3, input logic [31:0] d);
    int nb;
    logic [31:0] v;
    nb = 1 << f3[1:0];
    v = 0;
    for (int lane = 0; lane < 4; lane++) v[8*lane +: 8] = d[8*(lane % nb) +: 8];
    return v;
  endfunction

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic        preset_en;
    logic [31:0] preset;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wbdata;
    logic [31:0] exp_ld;
    logic [1:0]  exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [0:10];
  res_t r;
  logic [31:0] held;
  logic stray_ok;

  initial begin
    vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 32'h0, 2'b00, 3};
    vecs[1]  = '{1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b0, 32'h0, 4'h8, 32'hA5A5A5A5, 32'h0, 2'b00, 3};
    vecs[2]  = '{1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 32'hA5000000, 4'h8, 32'h0, 32'hFFFFFFA5, 2'b00, 3};
    vecs[3]  = '{1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h0, 4'h8, 32'h0, 32'h000000A5, 2'b00, 3};
    vecs[4]  = '{1'b0, 3'b001, 32'h21, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b01, 1};
    vecs[5]  = '{1'b0, 3'b011, 32'h20, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b10, 1};
    vecs[6]  = '{1'b1, 3'b001, 32'h22, 32'h12348001, 1'b1, 32'h00001234, 4'hC, 32'h80018001, 32'h0, 2'b00, 3};
    vecs[7]  = '{1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 32'h0, 4'hC, 32'h0, 32'hFFFF8001, 2'b00, 3};
    vecs[8]  = '{1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h0, 4'hF, 32'h0, 32'h80011234, 2'b00, 3};
    vecs[9]  = '{1'b1, 3'b100, 32'h30, 32'h55, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b10, 1};
    vecs[10] = '{1'b1, 3'b010, 32'h22, 32'h55, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b01, 1};

    for (int i = 0; i < 64; i++) slv_mem[i] = 32'h0;
    rst_n = 1'b0; req = 1'b0; is_store = 1'b0; funct3 = 3'b0; addr = 32'h0; sdata = 32'h0;
    wb_rdata = 32'h0; ack = 1'b0; wb_stall = 1'b0;

    #12;
    chk("rst_cyc", {31'h0, cyc}, 32'h0);
    chk("rst_stb", {31'h0, stb}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {30'h0, err}, 32'h0);
    chk("rst_ld", ld, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i <= 10; i++) begin
      if (vecs[i].preset_en) slv_mem[vecs[i].a[7:2]] = vecs[i].preset;
      run_op(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].d, 0, 1, 1'b0, r);
      $display("vec %0d st=%0b f3=%0d addr=0x%02h ld=0x%08h err=%0d lat=%0d",
               i, vecs[i].st, vecs[i].f3, vecs[i].a, r.ld, r.err, r.latency);
      chk($sformatf("vec%0d_err", i), {30'h0, r.err}, {30'h0, vecs[i].exp_err});
      chk($sformatf("vec%0d_ld", i), r.ld, vecs[i].exp_ld);
      chk($sformatf("vec%0d_lat", i), r.latency, vecs[i].exp_lat);
      chk($sformatf("vec%0d_cyc", i), {31'h0, r.cyc_seen}, {31'h0, vecs[i].exp_err == 2'b00});
      if (vecs[i].exp_err == 2'b00) begin
        chk($sformatf("vec%0d_sel", i), {28'h0, r.sel}, {28'h0, vecs[i].exp_sel});
        chk($sformatf("vec%0d_we", i), {31'h0, r.we}, {31'h0, vecs[i].st});
        if (vecs[i].st) chk($sformatf("vec%0d_wbdata", i), r.wbdata, vecs[i].exp_wbdata);
      end
    end

    // Slave stalls the strobe for three cycles before taking it.
    slv_mem[8'h20 >> 2] = 32'h80015A5A;
    run_op(1'b0, 3'b101, 32'h22, 32'h0, 3, 1, 1'b0, r);
    $display("stall op: ld=0x%08h err=%0d stb_cycles=%0d lat=%0d", r.ld, r.err, r.stb_cycles, r.latency);
    chk("stall_stb_cycles", r.stb_cycles, 4);
    chk("stall_ld", r.ld, 32'h00008001);
    chk("stall_err", {30'h0, r.err}, 32'h0);
    chk("stall_lat", r.latency, 6);
    held = r.ld;

    // Acks while idle must not start or finish anything.
    stray_ok = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      ack = 1'b1;
      if (done !== 1'b0 || cyc !== 1'b0) stray_ok = 1'b0;
    end
    @(negedge clk);
    ack = 1'b0;
    if (done !== 1'b0 || cyc !== 1'b0) stray_ok = 1'b0;
    $display("stray acks in idle: clean=%0b ld=0x%08h", stray_ok, ld);
    chk("stray_ack_ignored", {31'h0, stray_ok}, 32'h1);
    chk("ld_held", ld, held);

    run_op(1'b0, 3'b010, 32'h40, 32'h0, 0, 0, 1'b1, r);
    $display("timeout op: err=%0d cyc_cycles=%0d ld=0x%08h lat=%0d", r.err, r.cyc_cycles, r.ld, r.latency);
    chk("to_err", {30'h0, r.err}, 32'h3);
    chk("to_cyc_cycles", r.cyc_cycles, 16);
    chk("to_ld", r.ld, 32'h0);
    chk("to_lat", r.latency, 17);

    run_op(1'b1, 3'b010, 32'h44, 32'h01020304, 0, 0, 1'b0, r);
    $display("ack-in-REQ op: err=%0d lat=%0d", r.err, r.latency);
    chk("fast_err", {30'h0, r.err}, 32'h0);
    chk("fast_lat", r.latency, 2);

    // Asynchronous reset while waiting for an ack.
    @(negedge clk);
    req = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h48;
    repeat (3) @(negedge clk);
    chk("wait_cyc_before_rst", {31'h0, cyc}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-WAIT: cyc=%0b stb=%0b done=%0b", cyc, stb, done);
    chk("rst_mid_cyc", {31'h0, cyc}, 32'h0);
    chk("rst_mid_stb", {31'h0, stb}, 32'h0);
    chk("rst_mid_done", {31'h0, done}, 32'h0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    for (int w = 0; w < 64; w++)
      slv_mem[w] = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};

    for (int t = 0; t < 80; t++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a, d, exp_ld;
      logic [1:0]  exp_err;
      int          sn, ad, exp_lat;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom_range(0, 255);
      d  = $urandom;
      sn = $urandom_range(0, 2);
      ad = $urandom_range(0, 2);
      exp_err = model_err(st, f3, a);
      exp_ld  = (exp_err == 2'b00 && !st) ? model_load(f3, a) : 32'h0;
      exp_lat = (exp_err != 2'b00) ? 1 : ((ad == 0) ? 2 + sn : 2 + sn + ad);
      run_op(st, f3, a, d, sn, ad, 1'b0, r);
      $display("rand %0d st=%0b f3=%0d addr=0x%02h ld=0x%08h err=%0d lat=%0d",
               t, st, f3, a, r.ld, r.err, r.latency);
      chk("rnd_err", {30'h0, r.err}, {30'h0, exp_err});
      chk("rnd_ld", r.ld, exp_ld);
      chk("rnd_lat", r.latency, exp_lat);
      chk("rnd_cyc", {31'h0, r.cyc_seen}, {31'h0, exp_err == 2'b00});
      if (exp_err == 2'b00) begin
        chk("rnd_sel", {28'h0, r.sel}, {28'h0, model_sel(f3, a)});
        if (st) begin
          chk("rnd_wbdata", r.wbdata, model_wbdata(f3, d));
          for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[(a + i) % 256] = d[8*i +: 8];
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
